// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point arithmetic blocks.
// Holds the divider FSM states, saturation limits and the counter width.
package fixed_point_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

    function automatic int div_cnt_width(input int dividend_width);
        return $clog2(dividend_width + 1);
    endfunction

    localparam int DIV_CNT_W = div_cnt_width(32);

    // Limits are returned 64 bits wide; callers keep the low 'width' bits.
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/fixed_point_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract,
// and keep the difference only when it did not go negative.
module fixed_point_div_step #(
    parameter int WORD_WIDTH_IN = 16
) (
    input  logic [WORD_WIDTH_IN:0]   rem_in,
    input  logic                     dividend_bit,
    input  logic [WORD_WIDTH_IN-1:0] divisor_mag,
    output logic [WORD_WIDTH_IN:0]   rem_out,
    output logic                     q_bit
);

    localparam int RW = WORD_WIDTH_IN + 1;

    always_comb begin
        q_bit   = ({rem_in, dividend_bit} >= {2'b00, divisor_mag});
        rem_out = q_bit ? RW'({rem_in, dividend_bit} - {2'b00, divisor_mag})
                        : RW'({rem_in, dividend_bit});
    end

endmodule

// File: rtl/fixed_point_div.sv
// Sequential signed fixed-point divider: D-bit dividend by N-bit divisor,
// one quotient bit per cycle, saturating quotient, valid/ready on both sides.
module fixed_point_div
    import fixed_point_pkg::*;
#(
    parameter int WORD_WIDTH_IN  = 16,
    parameter int DIVIDEND_WIDTH = 2 * WORD_WIDTH_IN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [WORD_WIDTH_IN-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_WIDTH_IN-1:0]  quotient,
    output logic [WORD_WIDTH_IN-1:0]  remainder,
    output logic                      overflow,
    output logic                      div_by_zero
);

    localparam int N     = WORD_WIDTH_IN;
    localparam int D     = DIVIDEND_WIDTH;
    localparam int CNT_W = div_cnt_width(D);

    localparam logic [63:0]      SAT_MAX_W = sat_max(N);
    localparam logic [63:0]      SAT_MIN_W = sat_min(N);
    localparam logic [N-1:0]     Q_MAX     = SAT_MAX_W[N-1:0];
    localparam logic [N-1:0]     Q_MIN     = SAT_MIN_W[N-1:0];
    localparam logic [D-1:0]     POS_LIM   = D'(SAT_MAX_W);
    localparam logic [D-1:0]     NEG_LIM   = POS_LIM + D'(1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(D - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [D-1:0]     dvd_q, dvd_d;
    logic [N-1:0]     dvsr_q, dvsr_d;
    logic [N:0]       rem_q, rem_d;
    logic [D-1:0]     quo_q, quo_d;
    logic             neg_q, neg_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dz_q, dz_d;
    logic [N-1:0]     quotient_q, quotient_d;
    logic [N-1:0]     remainder_q, remainder_d;
    logic             overflow_q, overflow_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [N:0]       step_rem;
    logic             step_q;

    fixed_point_div_step #(
        .WORD_WIDTH_IN (N)
    ) u_step (
        .rem_in       (rem_q),
        .dividend_bit (dvd_q[D-1]),
        .divisor_mag  (dvsr_q),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dvd_q         <= '0;
            dvsr_q        <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            neg_q         <= 1'b0;
            dvd_neg_q     <= 1'b0;
            dz_q          <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dvd_q         <= dvd_d;
            dvsr_q        <= dvsr_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            neg_q         <= neg_d;
            dvd_neg_q     <= dvd_neg_d;
            dz_q          <= dz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            overflow_q    <= overflow_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = (divisor == '0) ? FIX : CALC;
            CALC: if (cnt_q == LAST_CNT) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are stored as magnitudes; signs are reapplied in FIX.
    always_comb begin
        cnt_d         = cnt_q;
        dvd_d         = dvd_q;
        dvsr_d        = dvsr_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        neg_d         = neg_q;
        dvd_neg_d     = dvd_neg_q;
        dz_d          = dz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        overflow_d    = overflow_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d     = dividend[D-1] ? -dividend : dividend;
                    dvsr_d    = divisor[N-1] ? -divisor : divisor;
                    neg_d     = dividend[D-1] ^ divisor[N-1];
                    dvd_neg_d = dividend[D-1];
                    dz_d      = (divisor == '0);
                    rem_d     = '0;
                    quo_d     = '0;
                    cnt_d     = '0;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[D-2:0], 1'b0};
                quo_d = {quo_q[D-2:0], step_q};
                cnt_d = cnt_q + CNT_W'(1);
            end
            FIX: begin
                div_by_zero_d = dz_q;
                if (dz_q) begin
                    quotient_d  = dvd_neg_q ? Q_MIN : Q_MAX;
                    remainder_d = '0;
                    overflow_d  = 1'b0;
                end else if (neg_q ? (quo_q > NEG_LIM) : (quo_q > POS_LIM)) begin
                    quotient_d  = neg_q ? Q_MIN : Q_MAX;
                    remainder_d = '0;
                    overflow_d  = 1'b1;
                end else begin
                    quotient_d  = neg_q ? -quo_q[N-1:0] : quo_q[N-1:0];
                    remainder_d = dvd_neg_q ? -rem_q[N-1:0] : rem_q[N-1:0];
                    overflow_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        quotient    = quotient_q;
        remainder   = remainder_q;
        overflow    = overflow_q;
        div_by_zero = div_by_zero_q;
    end

endmodule
